maverick_mp_regfile: RTL and testbench

Parametrised multi-port integer register file with a per-register lock scoreboard. Each register carries an up/down pending-write counter, so several writes can be in flight to the same register, not just one lock bit. It sits between issue/dispatch, which locks destination registers, and writeback, which writes data and releases locks. It feeds NUM_RD operand read ports.

---
 rtl/maverickOne_pkg.sv | 19 +
 rtl/maverick_lock_counter.sv | 51 +++++
 rtl/maverick_mp_regfile.sv | 141 ++++++++++++++
 tb/tb_maverick_mp_regfile.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maverickOne_pkg.sv
// Shared types and constants for the maverick multi-port register file.
// Holds the default architectural sizes, the address/data typedefs and the
// pending-write counter width used by the lock scoreboard.
package maverickOne_pkg;

  localparam int NUM_REGS = 32;
  localparam int XLEN     = 64;
  localparam int RF_AW    = $clog2(NUM_REGS);
  localparam int RF_CNT_W = 2;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [XLEN-1:0]  rf_data_t;

  // Largest value an unsigned counter of the given width can hold.
  function automatic int cnt_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/maverick_lock_counter.sv
// One pending-write counter of the lock scoreboard. Counts accepted locks up
// and writebacks down in the same cycle, clamps at zero and at its maximum,
// and clears to zero when clr_i is high (clear wins over inc/dec).
module maverick_lock_counter
  import maverickOne_pkg::*;
#(
  parameter int CNT_W = RF_CNT_W,
  parameter int INC_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             clr_i,
  input  logic [INC_W-1:0] inc_i,
  input  logic [DEC_W-1:0] dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o
);

  localparam int CNT_MAX = cnt_max(CNT_W);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  int               sum;

  // Next count: net of this cycle's locks and writebacks, clamped to range.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    sum   = int'(cnt_q) + int'(inc_i) - int'(dec_i);
    if (clr_i) begin
      cnt_d = '0;
    end else if (sum < 0) begin
      cnt_d = '0;
    end else if (sum > CNT_MAX) begin
      cnt_d = CNT_W'(CNT_MAX);
    end else begin
      cnt_d = CNT_W'(sum);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (!arst_ni) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/maverick_mp_regfile.sv
// Multi-port integer register file with a per-register pending-write
// scoreboard. Issue locks destination registers through the lock ports,
// writeback writes data and releases one lock per port. r0 reads as zero,
// ignores writes and never shows as locked once initialisation is done.
// Optional build macro MAVERICK_MP_REGFILE_FWD_EN adds a same-cycle
// write-to-read bypass on the read ports; locking is unaffected by it.
module maverick_mp_regfile
  import maverickOne_pkg::*;
#(
  parameter  int NUM_REGS = maverickOne_pkg::NUM_REGS,
  parameter  int XLEN     = maverickOne_pkg::XLEN,
  parameter  int NUM_RD   = 3,
  parameter  int NUM_WR   = 2,
  parameter  int NUM_LOCK = 2,
  parameter  int CNT_W    = RF_CNT_W,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           arst_ni,
  input  logic                           flush_i,
  input  logic [NUM_LOCK-1:0]            lock_en_i,
  input  logic [NUM_LOCK-1:0][AW-1:0]    lock_addr_i,
  output logic [NUM_LOCK-1:0]            lock_ready_o,
  input  logic [NUM_WR-1:0]              wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]      wr_addr_i,
  input  logic [NUM_WR-1:0][XLEN-1:0]    wr_data_i,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr_i,
  output logic [NUM_RD-1:0][XLEN-1:0]    rd_data_o,
  output logic [NUM_REGS-1:0]            locks_o
);

  localparam int CNT_MAX = cnt_max(CNT_W);
  localparam int INC_W   = $clog2(NUM_LOCK + 1);
  localparam int DEC_W   = $clog2(NUM_WR + 1);

  logic                init_q, init_d;
  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [XLEN-1:0]     regs_d [NUM_REGS];
  logic [CNT_W-1:0]    cnt_all [NUM_REGS];
  logic [INC_W-1:0]    inc_cnt [NUM_REGS];
  logic [DEC_W-1:0]    dec_cnt [NUM_REGS];
  logic [NUM_REGS-1:1] busy;
  logic [NUM_LOCK-1:0] lock_acc;

  // Init flag: high from reset until the first clock edge afterwards.
  always_comb begin
    init_d = 1'b0;
  end

  // Init flag register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) init_q <= 1'b1;
    else          init_q <= init_d;
  end

  // Register array next state: later write ports override earlier ones.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w] != '0)) begin
        regs_d[wr_addr_i[w]] = wr_data_i[w];
      end
    end
    regs_d[0] = '0;
  end

  // Register array storage, cleared by reset.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    // NOTE: this array is reset on purpose because reads of untouched registers must return zero.
    if (!arst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Lock readiness: conservative headroom check so no counter can overflow.
  always_comb begin
    lock_ready_o = '0;
    for (int k = 0; k < NUM_LOCK; k++) begin
      lock_ready_o[k] = !init_q && !flush_i &&
                        (int'(cnt_all[lock_addr_i[k]]) <= CNT_MAX - NUM_LOCK);
    end
  end

  assign lock_acc = lock_en_i & lock_ready_o;

  // Per-register increment (accepted locks) and decrement (writebacks) counts.
  always_comb begin
    inc_cnt = '{default: '0};
    dec_cnt = '{default: '0};
    for (int k = 0; k < NUM_LOCK; k++) begin
      if (lock_acc[k]) begin
        inc_cnt[lock_addr_i[k]] = inc_cnt[lock_addr_i[k]] + INC_W'(1);
      end
    end
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w]) begin
        dec_cnt[wr_addr_i[w]] = dec_cnt[wr_addr_i[w]] + DEC_W'(1);
      end
    end
  end

  assign cnt_all[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    maverick_lock_counter #(
      .CNT_W (CNT_W),
      .INC_W (INC_W),
      .DEC_W (DEC_W)
    ) u_cnt (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .clr_i   (flush_i),
      .inc_i   (inc_cnt[r]),
      .dec_i   (dec_cnt[r]),
      .cnt_o   (cnt_all[r]),
      .busy_o  (busy[r])
    );
  end

  assign locks_o = init_q ? '1 : {busy, 1'b0};

  // Combinational read ports, with optional same-cycle writeback bypass.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data_o[k] = regs_q[rd_addr_i[k]];
`ifdef MAVERICK_MP_REGFILE_FWD_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w] == rd_addr_i[k])) begin
          rd_data_o[k] = wr_data_i[w];
        end
      end
`else
`endif
      if (rd_addr_i[k] == '0) rd_data_o[k] = '0;
    end
  end

endmodule

// File: tb/tb_maverick_mp_regfile.sv
// Self-checking bench for maverick_mp_regfile: reset, a table of directed
// single-cycle vectors, an asynchronous mid-operation reset, and a random
// soak against a behavioural reference model with a locks_o scoreboard.
module tb_maverick_mp_regfile;
  import maverickOne_pkg::*;

  localparam int NREG     = 32;
  localparam int NRD      = 3;
  localparam int NWR      = 2;
  localparam int NLK      = 2;
  localparam int AWB      = 5;
  localparam int READY_LIM = 3 - NLK;  // counter max 3 minus lock ports
  localparam int SOAK     = 2000;

`ifdef MAVERICK_MP_REGFILE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                        clk;
  logic                        arst_ni;
  logic                        flush;
  logic [NLK-1:0]              lock_en;
  logic [NLK-1:0][AWB-1:0]     lock_addr;
  logic [NLK-1:0]              lock_ready;
  logic [NWR-1:0]              wr_en;
  logic [NWR-1:0][AWB-1:0]     wr_addr;
  logic [NWR-1:0][63:0]        wr_data;
  logic [NRD-1:0][AWB-1:0]     rd_addr;
  logic [NRD-1:0][63:0]        rd_data;
  logic [NREG-1:0]             locks;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q [$];

  rf_data_t m_regs [NREG];
  int       m_cnt  [NREG];

  typedef struct {
    logic        flush;
    logic [1:0]  lock_en;
    int          la0, la1;
    logic [1:0]  wr_en;
    int          wa0, wa1;
    logic [63:0] wd0, wd1;
    int          ra;
    logic [1:0]  exp_ready;
    logic [63:0] exp_rd_old;
    logic [63:0] exp_rd_fwd;
    logic [31:0] exp_locks;
  } vec_t;

  vec_t vecs [$];

  maverick_mp_regfile dut (
    .clk_i        (clk),
    .arst_ni      (arst_ni),
    .flush_i      (flush),
    .lock_en_i    (lock_en),
    .lock_addr_i  (lock_addr),
    .lock_ready_o (lock_ready),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .locks_o      (locks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic [1:0] le, input int la0, input int la1,
                       input logic [1:0] we, input int wa0, input int wa1,
                       input logic [63:0] wd0, input logic [63:0] wd1,
                       input int ra0, input int ra1, input int ra2);
    flush        = fl;
    lock_en      = le;
    lock_addr[0] = rf_addr_t'(la0);
    lock_addr[1] = rf_addr_t'(la1);
    wr_en        = we;
    wr_addr[0]   = rf_addr_t'(wa0);
    wr_addr[1]   = rf_addr_t'(wa1);
    wr_data[0]   = wd0;
    wr_data[1]   = wd1;
    rd_addr[0]   = rf_addr_t'(ra0);
    rd_addr[1]   = rf_addr_t'(ra1);
    rd_addr[2]   = rf_addr_t'(ra2);
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 0, 0, 2'b00, 0, 0, 64'h0, 64'h0, 0, 0, 0);
  endtask

  task automatic add(input logic fl, input logic [1:0] le, input int la0, input int la1,
                     input logic [1:0] we, input int wa0, input int wa1,
                     input logic [63:0] wd0, input logic [63:0] wd1, input int ra,
                     input logic [1:0] er, input logic [63:0] eold, input logic [63:0] efwd,
                     input logic [31:0] el);
    vec_t v;
    v.flush = fl; v.lock_en = le; v.la0 = la0; v.la1 = la1;
    v.wr_en = we; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1; v.ra = ra;
    v.exp_ready = er; v.exp_rd_old = eold; v.exp_rd_fwd = efwd; v.exp_locks = el;
    vecs.push_back(v);
  endtask

  // Pop one expected locks_o value and compare it after the edge.
  task automatic sb_check(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 256'(1), 256'(0));
    end else begin
      e = exp_q.pop_front();
      check(name, 256'(locks), 256'(e));
    end
  endtask

  task automatic run_table();
    vec_t        v;
    logic [63:0] erd;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v.flush, v.lock_en, v.la0, v.la1, v.wr_en, v.wa0, v.wa1, v.wd0, v.wd1,
            v.ra, v.ra, v.ra);
      erd = FWD ? v.exp_rd_fwd : v.exp_rd_old;
      exp_q.push_back(v.exp_locks);
      #1;
      check($sformatf("vec%0d_ready", i), 256'(lock_ready), 256'(v.exp_ready));
      check($sformatf("vec%0d_rd", i), 256'(rd_data), 256'({erd, erd, erd}));
      @(posedge clk);
      #1;
      sb_check($sformatf("vec%0d_locks", i));
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
  endtask

  task automatic soak();
    logic [NLK-1:0]       e_ready;
    logic [NRD-1:0][63:0] e_rd;
    logic [31:0]          e_locks;
    int                   inc, dec, nv;
    for (int c = 0; c < SOAK; c++) begin
      @(negedge clk);
      flush = ($urandom_range(0, 31) == 0);
      lock_en = 2'($urandom_range(0, 3));
      wr_en   = 2'($urandom_range(0, 3));
      for (int k = 0; k < NLK; k++) lock_addr[k] = rf_addr_t'($urandom_range(0, 7));
      for (int w = 0; w < NWR; w++) begin
        wr_addr[w] = rf_addr_t'($urandom_range(0, 7));
        wr_data[w] = {$urandom, $urandom};
      end
      for (int k = 0; k < NRD; k++) rd_addr[k] = rf_addr_t'($urandom_range(0, 7));

      for (int k = 0; k < NLK; k++)
        e_ready[k] = !flush && (m_cnt[lock_addr[k]] <= READY_LIM);
      for (int k = 0; k < NRD; k++) begin
        e_rd[k] = m_regs[rd_addr[k]];
        if (FWD) begin
          for (int w = 0; w < NWR; w++)
            if (wr_en[w] && wr_addr[w] == rd_addr[k]) e_rd[k] = wr_data[w];
        end
        if (rd_addr[k] == 0) e_rd[k] = '0;
      end
      #1;
      check($sformatf("soak%0d_ready", c), 256'(lock_ready), 256'(e_ready));
      check($sformatf("soak%0d_rd", c), 256'(rd_data), 256'(e_rd));

      for (int r = 1; r < NREG; r++) begin
        inc = 0;
        dec = 0;
        for (int k = 0; k < NLK; k++) if (lock_en[k] && e_ready[k] && lock_addr[k] == r) inc++;
        for (int w = 0; w < NWR; w++) if (wr_en[w] && wr_addr[w] == r) dec++;
        nv = m_cnt[r] + inc - dec;
        if (nv < 0) nv = 0;
        if (flush) nv = 0;
        m_cnt[r] = nv;
      end
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wr_addr[w] != 0) m_regs[wr_addr[w]] = wr_data[w];
      e_locks = '0;
      for (int r = 1; r < NREG; r++) e_locks[r] = (m_cnt[r] != 0);
      exp_q.push_back(e_locks);

      @(posedge clk);
      #1;
      sb_check($sformatf("soak%0d_locks", c));
    end
  endtask

  initial begin
    // Directed vectors: state carries over from one row to the next.
    //  fl  lock la0 la1 wr   wa0 wa1 wd0          wd1          ra  ready old          fwd          locks
    add(0, 2'b01, 5, 0, 2'b00, 0, 0, 64'h0,       64'h0,       5, 2'b11, 64'h0,       64'h0,       32'h20);
    add(0, 2'b01, 5, 0, 2'b00, 0, 0, 64'h0,       64'h0,       5, 2'b11, 64'h0,       64'h0,       32'h20);
    add(0, 2'b00, 5, 0, 2'b01, 5, 0, 64'hDEAD,    64'h0,       5, 2'b10, 64'h0,       64'hDEAD,    32'h20);
    add(0, 2'b00, 5, 0, 2'b10, 0, 5, 64'h0,       64'hBEEF,    5, 2'b11, 64'hDEAD,    64'hBEEF,    32'h0);
    add(0, 2'b00, 5, 0, 2'b00, 0, 0, 64'h0,       64'h0,       5, 2'b11, 64'hBEEF,    64'hBEEF,    32'h0);
    add(0, 2'b11, 7, 7, 2'b00, 0, 0, 64'h0,       64'h0,       7, 2'b11, 64'h0,       64'h0,       32'h80);
    add(0, 2'b01, 7, 7, 2'b00, 0, 0, 64'h0,       64'h0,       7, 2'b00, 64'h0,       64'h0,       32'h80);
    add(0, 2'b00, 7, 7, 2'b01, 7, 0, 64'h77,      64'h0,       7, 2'b00, 64'h0,       64'h77,      32'h80);
    add(0, 2'b00, 7, 7, 2'b00, 0, 0, 64'h0,       64'h0,       7, 2'b11, 64'h77,      64'h77,      32'h80);
    add(0, 2'b00, 7, 7, 2'b01, 7, 0, 64'h78,      64'h0,       7, 2'b11, 64'h77,      64'h78,      32'h0);
    add(0, 2'b11, 3, 3, 2'b00, 0, 0, 64'h0,       64'h0,       3, 2'b11, 64'h0,       64'h0,       32'h8);
    add(0, 2'b00, 3, 3, 2'b11, 3, 3, 64'h11,      64'h22,      3, 2'b00, 64'h0,       64'h22,      32'h0);
    add(0, 2'b00, 3, 3, 2'b00, 0, 0, 64'h0,       64'h0,       3, 2'b11, 64'h22,      64'h22,      32'h0);
    add(0, 2'b01, 9, 0, 2'b00, 0, 0, 64'h0,       64'h0,       9, 2'b11, 64'h0,       64'h0,       32'h200);
    add(0, 2'b01, 9, 0, 2'b01, 9, 0, 64'h99,      64'h0,       9, 2'b11, 64'h0,       64'h99,      32'h200);
    add(0, 2'b00, 9, 0, 2'b10, 0, 9, 64'h0,       64'h9A,      9, 2'b11, 64'h99,      64'h9A,      32'h0);
    add(0, 2'b00, 0, 0, 2'b01, 10, 0, 64'hA0,     64'h0,      10, 2'b11, 64'h0,       64'hA0,      32'h0);
    add(0, 2'b00, 0, 0, 2'b01, 0, 0, 64'hFF,      64'h0,       0, 2'b11, 64'h0,       64'h0,       32'h0);
    add(0, 2'b11, 0, 0, 2'b00, 0, 0, 64'h0,       64'h0,       0, 2'b11, 64'h0,       64'h0,       32'h0);
    add(0, 2'b11, 4, 6, 2'b00, 0, 0, 64'h0,       64'h0,       4, 2'b11, 64'h0,       64'h0,       32'h50);
    add(1, 2'b11, 4, 6, 2'b01, 4, 0, 64'h44,      64'h0,       4, 2'b00, 64'h0,       64'h44,      32'h0);
    add(0, 2'b00, 4, 6, 2'b00, 0, 0, 64'h0,       64'h0,       4, 2'b11, 64'h44,      64'h44,      32'h0);
    add(0, 2'b00, 0, 0, 2'b10, 0, 12, 64'h0,      64'h1212,   12, 2'b11, 64'h0,       64'h1212,    32'h0);
    add(0, 2'b00, 0, 0, 2'b01, 12, 0, 64'hCAFE,   64'h0,      12, 2'b11, 64'h1212,    64'hCAFE,    32'h0);
    add(0, 2'b00, 0, 0, 2'b00, 0, 0, 64'h0,       64'h0,      12, 2'b11, 64'hCAFE,    64'hCAFE,    32'h0);

    // Power-on reset: init state forces all locks on and no lock readiness.
    arst_ni = 1'b0;
    drive(1'b0, 2'b11, 1, 2, 2'b00, 0, 0, 64'h0, 64'h0, 1, 5, 31);
    #100;
    check("reset_locks", 256'(locks), 256'(32'hFFFF_FFFF));
    check("reset_ready", 256'(lock_ready), 256'(2'b00));
    #2;
    arst_ni = 1'b1;
    #1;
    check("init_hold_locks", 256'(locks), 256'(32'hFFFF_FFFF));
    @(posedge clk);
    #1;
    check("post_init_locks", 256'(locks), 256'(0));
    check("post_init_rd", 256'(rd_data), 256'(0));
    @(negedge clk);
    idle();

    run_table();

    // Mid-operation asynchronous reset drops in-flight locks and data.
    @(negedge clk);
    drive(1'b0, 2'b01, 2, 0, 2'b00, 0, 0, 64'h0, 64'h0, 3, 12, 5);
    @(posedge clk);
    #1;
    check("pre_reset_lock_r2", 256'(locks), 256'(32'h4));
    #2;
    arst_ni = 1'b0;
    #1;
    check("midreset_locks", 256'(locks), 256'(32'hFFFF_FFFF));
    check("midreset_ready", 256'(lock_ready), 256'(2'b00));
    check("midreset_rd", 256'(rd_data), 256'(0));
    @(negedge clk);
    idle();
    arst_ni = 1'b1;
    @(posedge clk);
    #1;
    check("post_midreset_locks", 256'(locks), 256'(0));
    model_clear();

    soak();

    @(negedge clk);
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
